alu_op_issue: RTL and testbench

//   Issue stage that feeds the execute-stage ALU: decodes ALUOp plus the

---
 rtl/alu_op_issue.sv | 133 +++++++++++++
 tb/tb_alu_op_issue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issue.sv
// Issue stage ahead of the execute ALU. It decodes ALUOp/opcode into ALUControl,
// registers the op with its operands, and uses a 2-entry skid buffer so in_ready is a register.
module alu_op_issue #(
    parameter int N     = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [10:0]      opcode,
    input  logic [N-1:0]     a_in,
    input  logic [N-1:0]     b_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     a,
    output logic [N-1:0]     b,
    output logic [3:0]       alu_control,
    output logic             illegal,
    output logic [CNT_W-1:0] issued_cnt
);

    // Returns {illegal, alu_control}.
    function automatic logic [4:0] f_decode(input logic [1:0] op, input logic [10:0] opc);
        logic [4:0] res;
        res = 5'b0_0000;
        case (op)
            2'b00: res = 5'b0_0010;
            2'b01: res = 5'b0_0111;
            2'b11: res = 5'b0_1111;
            default: begin
                case (opc)
                    11'b10001011000: res = 5'b0_0010;
                    11'b11001011000: res = 5'b0_0110;
                    11'b10001010000: res = 5'b0_0000;
                    11'b10101010000: res = 5'b0_0001;
                    default:         res = 5'b1_0000;
                endcase
            end
        endcase
        return res;
    endfunction

    logic             r_m_vld;
    logic [N-1:0]     r_m_a;
    logic [N-1:0]     r_m_b;
    logic [3:0]       r_m_ctl;
    logic             r_m_ill;
    logic             r_s_vld;
    logic [N-1:0]     r_s_a;
    logic [N-1:0]     r_s_b;
    logic [3:0]       r_s_ctl;
    logic             r_s_ill;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_cnt;

    logic             w_acc;
    logic             w_iss;
    logic             w_m_free;
    logic [4:0]       w_dec;

    assign w_acc    = in_valid & r_in_ready;
    assign w_iss    = r_m_vld & out_ready;
    assign w_m_free = !r_m_vld || w_iss;
    assign w_dec    = f_decode(alu_op, opcode);

    // S can only be full while M is held, and in_ready is low whenever S is full,
    // so an accept never coincides with S draining into M.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_vld    <= 1'b0;
            r_m_a      <= '0;
            r_m_b      <= '0;
            r_m_ctl    <= 4'b0000;
            r_m_ill    <= 1'b0;
            r_s_vld    <= 1'b0;
            r_s_a      <= '0;
            r_s_b      <= '0;
            r_s_ctl    <= 4'b0000;
            r_s_ill    <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_m_vld    <= 1'b0;
            r_s_vld    <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (w_m_free) begin
            if (r_s_vld) begin
                r_m_vld    <= 1'b1;
                r_m_a      <= r_s_a;
                r_m_b      <= r_s_b;
                r_m_ctl    <= r_s_ctl;
                r_m_ill    <= r_s_ill;
                r_s_vld    <= 1'b0;
                r_in_ready <= 1'b1;
            end else if (w_acc) begin
                r_m_vld <= 1'b1;
                r_m_a   <= a_in;
                r_m_b   <= b_in;
                r_m_ctl <= w_dec[3:0];
                r_m_ill <= w_dec[4];
            end else begin
                r_m_vld <= 1'b0;
            end
        end else if (w_acc) begin
            r_s_vld    <= 1'b1;
            r_s_a      <= a_in;
            r_s_b      <= b_in;
            r_s_ctl    <= w_dec[3:0];
            r_s_ill    <= w_dec[4];
            r_in_ready <= 1'b0;
        end
    end

    // The counter tracks completed handshakes, so an issue in a flush cycle still counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_iss) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_m_vld;
    assign a           = r_m_a;
    assign b           = r_m_b;
    assign alu_control = r_m_ctl;
    assign illegal     = r_m_ill;
    assign issued_cnt  = r_cnt;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: decode table, streaming, back-pressure, flush,
// async reset and counter wrap, using a small CNT_W so the wrap is reachable.
module tb_alu_op_issue;

    localparam int N     = 64;
    localparam int CNT_W = 2;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [10:0]      opcode;
    logic [N-1:0]     a_in;
    logic [N-1:0]     b_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [3:0]       alu_control;
    logic             illegal;
    logic [CNT_W-1:0] issued_cnt;

    int pass_cnt = 0;
    int total    = 0;

    alu_op_issue #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .opcode     (opcode),
        .a_in       (a_in),
        .b_in       (b_in),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .a          (a),
        .b          (b),
        .alu_control(alu_control),
        .illegal    (illegal),
        .issued_cnt (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [10:0] opc_tab [0:2];
    logic [3:0]  ctl_tab [0:2];

    initial begin
        opc_tab[0] = 11'b10001010000; ctl_tab[0] = 4'b0000;
        opc_tab[1] = 11'b10101010000; ctl_tab[1] = 4'b0001;
        opc_tab[2] = 11'b10001011000; ctl_tab[2] = 4'b0010;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        alu_op    = 2'b00;
        opcode    = 11'd0;
        a_in      = '0;
        b_in      = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_a", a, 64'd0);
        chk("rst_b", b, 64'd0);
        chk("rst_ctl", 64'(alu_control), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_cnt", 64'(issued_cnt), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single SUB op
        in_valid = 1'b1; alu_op = 2'b10; opcode = 11'b11001011000;
        a_in = 64'd9; b_in = 64'd4; out_ready = 1'b1;
        step();
        chk("sub_valid", 64'(out_valid), 64'd1);
        chk("sub_ctl", 64'(alu_control), 64'h6);
        chk("sub_a", a, 64'd9);
        chk("sub_b", b, 64'd4);
        chk("sub_illegal", 64'(illegal), 64'd0);
        in_valid = 1'b0;
        step();
        chk("sub_drained", 64'(out_valid), 64'd0);
        chk("cnt_after_sub", 64'(issued_cnt), 64'd1);

        // Stream 1..6, one per cycle
        alu_op = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; a_in = 64'(i); b_in = 64'(i * 10);
            step();
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_a", a, 64'(i));
            chk("stream_b", b, 64'(i * 10));
            chk("stream_ctl", 64'(alu_control), 64'h2);
            chk("stream_in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", 64'(out_valid), 64'd0);
        chk("cnt_after_stream", 64'(issued_cnt), 64'd3);  // 7 issues mod 4

        // Back-pressure: third op must be refused
        out_ready = 1'b0;
        in_valid = 1'b1; a_in = 64'd1; b_in = 64'd11;
        step();
        chk("bp1_in_ready", 64'(in_ready), 64'd1);
        chk("bp1_a", a, 64'd1);
        a_in = 64'd2; b_in = 64'd22;
        step();
        chk("bp2_in_ready", 64'(in_ready), 64'd0);
        chk("bp2_a_stable", a, 64'd1);
        chk("bp2_valid", 64'(out_valid), 64'd1);
        a_in = 64'd3; b_in = 64'd33;
        step();
        chk("bp3_in_ready", 64'(in_ready), 64'd0);
        chk("bp3_a_stable", a, 64'd1);
        chk("bp3_b_stable", b, 64'd11);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("bp_out2_a", a, 64'd2);
        chk("bp_out2_b", b, 64'd22);
        chk("bp_out2_valid", 64'(out_valid), 64'd1);
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);
        step();
        chk("bp_no_op3", 64'(out_valid), 64'd0);
        chk("cnt_after_bp", 64'(issued_cnt), 64'd1);  // 9 issues mod 4

        // Decode table
        in_valid = 1'b1; alu_op = 2'b10; opcode = 11'b11111111111;
        step();
        chk("dec_illegal_ctl", 64'(alu_control), 64'h0);
        chk("dec_illegal_flag", 64'(illegal), 64'd1);
        alu_op = 2'b01;
        step();
        chk("dec_cbz_ctl", 64'(alu_control), 64'h7);
        chk("dec_cbz_illegal", 64'(illegal), 64'd0);
        alu_op = 2'b11;
        step();
        chk("dec_movz_ctl", 64'(alu_control), 64'hF);
        alu_op = 2'b10;
        for (int i = 0; i < 3; i++) begin
            opcode = opc_tab[i];
            step();
            chk("dec_rtype_ctl", 64'(alu_control), 64'(ctl_tab[i]));
            chk("dec_rtype_illegal", 64'(illegal), 64'd0);
        end
        in_valid = 1'b0;
        step();
        chk("cnt_after_dec", 64'(issued_cnt), 64'd3);  // 15 issues mod 4

        // Flush with M and S full and a pending accept
        out_ready = 1'b0; alu_op = 2'b00;
        in_valid = 1'b1; a_in = 64'd100;
        step();
        a_in = 64'd101;
        step();
        chk("fl_full_in_ready", 64'(in_ready), 64'd0);
        a_in = 64'd102; flush = 1'b1;
        step();
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("fl_nothing_after", 64'(out_valid), 64'd0);
        in_valid = 1'b1; a_in = 64'd103; flush = 1'b1;
        step();
        chk("fl_accept_discarded", 64'(out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("fl_still_empty", 64'(out_valid), 64'd0);
        chk("fl_cnt_kept", 64'(issued_cnt), 64'd3);
        in_valid = 1'b1; a_in = 64'd104;
        step();
        chk("fl_iss_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_iss_counted", 64'(issued_cnt), 64'd0);
        chk("fl_iss_empty", 64'(out_valid), 64'd0);

        // Async reset between edges
        out_ready = 1'b0; in_valid = 1'b1; a_in = 64'd55; b_in = 64'd66;
        step();
        chk("ar_loaded", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_a", a, 64'd0);
        chk("ar_b", b, 64'd0);
        chk("ar_cnt", 64'(issued_cnt), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Counter wrap: 5 issues with CNT_W=2
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a_in = 64'(200 + i);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("wrap_cnt", 64'(issued_cnt), 64'd1);
        chk("wrap_last_a", a, 64'd204);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
